// File: rtl/clint_ctrl.sv
// Core-local interrupt/trap sequencer: writes mepc/mcause/mstatus, then redirects fetch.
// Define CLINT_VECTORED_EN for vectored interrupt targets when mtvec.MODE==1.
module clint_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_valid_i,
  input  logic [63:0] inst_pc_i,
  input  logic        inst_ecall_i,
  input  logic        inst_mret_i,
  input  logic [63:0] csr_mtvec_i,
  input  logic [63:0] csr_mepc_i,
  input  logic [63:0] csr_mstatus_i,
  input  logic        global_int_en_i,
  input  logic        mtime_int_en_i,
  input  logic        mtime_int_pend_i,
  output logic        clint_csr_wen_o,
  output logic [11:0] clint_csr_waddr_o,
  output logic [63:0] clint_csr_wdata_o,
  output logic        hold_o,
  output logic        redirect_valid_o,
  output logic [63:0] redirect_pc_o
);

  localparam logic [11:0] A_MSTATUS = 12'h300;
  localparam logic [11:0] A_MEPC    = 12'h341;
  localparam logic [11:0] A_MCAUSE  = 12'h342;
  localparam logic [63:0] C_MTIMER  = {1'b1, 63'd7};
  localparam logic [63:0] C_ECALL   = 64'd11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_W_MEPC,
    S_W_MCAUSE,
    S_W_MSTAT,
    S_M_MSTAT,
    S_JUMP
  } state_e;

  state_e      state_q, state_d;
  logic [63:0] pc_q, pc_d;
  logic [63:0] cause_q, cause_d;
  logic        mret_q, mret_d;

  logic        take_irq, take_ecall, take_mret, take_any;
  logic [63:0] mtvec_base, trap_tgt;
  logic [63:0] mstat_trap, mstat_mret;

  assign take_irq   = inst_valid_i & global_int_en_i
                    & mtime_int_en_i & mtime_int_pend_i;
  assign take_ecall = inst_valid_i & inst_ecall_i;
  assign take_mret  = inst_valid_i & inst_mret_i;
  assign take_any   = (state_q == S_IDLE)
                    & (take_irq | take_ecall | take_mret);

  assign mtvec_base = {csr_mtvec_i[63:2], 2'b00};

`ifdef CLINT_VECTORED_EN
  always_comb begin
    trap_tgt = mtvec_base;
    if (csr_mtvec_i[1:0] == 2'b01 && cause_q[63])
      trap_tgt = mtvec_base + {cause_q[61:0], 2'b00};
  end
`else
  logic unused_mode;
  assign unused_mode = &csr_mtvec_i[1:0];
  assign trap_tgt    = mtvec_base;
`endif

  always_comb begin
    mstat_trap        = csr_mstatus_i;
    mstat_trap[7]     = csr_mstatus_i[3];
    mstat_trap[3]     = 1'b0;
    mstat_trap[12:11] = 2'b11;
  end

  always_comb begin
    mstat_mret        = csr_mstatus_i;
    mstat_mret[3]     = csr_mstatus_i[7];
    mstat_mret[7]     = 1'b1;
    mstat_mret[12:11] = 2'b11;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      cause_q <= '0;
      mret_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cause_q <= cause_d;
      mret_q  <= mret_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cause_d = cause_q;
    mret_d  = mret_q;
    unique case (state_q)
      S_IDLE: begin
        if (take_irq) begin
          state_d = S_W_MEPC;
          pc_d    = inst_pc_i;
          cause_d = C_MTIMER;
          mret_d  = 1'b0;
        end else if (take_ecall) begin
          state_d = S_W_MEPC;
          pc_d    = inst_pc_i;
          cause_d = C_ECALL;
          mret_d  = 1'b0;
        end else if (take_mret) begin
          state_d = S_M_MSTAT;
          mret_d  = 1'b1;
        end
      end
      S_W_MEPC:   state_d = S_W_MCAUSE;
      S_W_MCAUSE: state_d = S_W_MSTAT;
      S_W_MSTAT:  state_d = S_JUMP;
      S_M_MSTAT:  state_d = S_JUMP;
      S_JUMP:     state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  always_comb begin
    clint_csr_wen_o   = 1'b0;
    clint_csr_waddr_o = '0;
    clint_csr_wdata_o = '0;
    redirect_valid_o  = 1'b0;
    redirect_pc_o     = '0;
    hold_o            = (state_q != S_IDLE) | take_any;
    unique case (state_q)
      S_W_MEPC: begin
        clint_csr_wen_o   = 1'b1;
        clint_csr_waddr_o = A_MEPC;
        clint_csr_wdata_o = pc_q;
      end
      S_W_MCAUSE: begin
        clint_csr_wen_o   = 1'b1;
        clint_csr_waddr_o = A_MCAUSE;
        clint_csr_wdata_o = cause_q;
      end
      S_W_MSTAT: begin
        clint_csr_wen_o   = 1'b1;
        clint_csr_waddr_o = A_MSTATUS;
        clint_csr_wdata_o = mstat_trap;
      end
      S_M_MSTAT: begin
        clint_csr_wen_o   = 1'b1;
        clint_csr_waddr_o = A_MSTATUS;
        clint_csr_wdata_o = mstat_mret;
      end
      S_JUMP: begin
        redirect_valid_o = 1'b1;
        redirect_pc_o    = mret_q ? csr_mepc_i : trap_tgt;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_clint_ctrl.sv
// Bench for clint_ctrl: queue-of-steps reference model plus directed literal checks.
// Build with +define+CLINT_VECTORED_EN to check the vectored configuration.
module tb_clint_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        inst_valid_i;
  logic [63:0] inst_pc_i;
  logic        inst_ecall_i;
  logic        inst_mret_i;
  logic [63:0] csr_mtvec_i;
  logic [63:0] csr_mepc_i;
  logic [63:0] csr_mstatus_i;
  logic        global_int_en_i;
  logic        mtime_int_en_i;
  logic        mtime_int_pend_i;
  logic        clint_csr_wen_o;
  logic [11:0] clint_csr_waddr_o;
  logic [63:0] clint_csr_wdata_o;
  logic        hold_o;
  logic        redirect_valid_o;
  logic [63:0] redirect_pc_o;

  clint_ctrl dut (
    .clk               (clk),
    .rst               (rst),
    .inst_valid_i      (inst_valid_i),
    .inst_pc_i         (inst_pc_i),
    .inst_ecall_i      (inst_ecall_i),
    .inst_mret_i       (inst_mret_i),
    .csr_mtvec_i       (csr_mtvec_i),
    .csr_mepc_i        (csr_mepc_i),
    .csr_mstatus_i     (csr_mstatus_i),
    .global_int_en_i   (global_int_en_i),
    .mtime_int_en_i    (mtime_int_en_i),
    .mtime_int_pend_i  (mtime_int_pend_i),
    .clint_csr_wen_o   (clint_csr_wen_o),
    .clint_csr_waddr_o (clint_csr_waddr_o),
    .clint_csr_wdata_o (clint_csr_wdata_o),
    .hold_o            (hold_o),
    .redirect_valid_o  (redirect_valid_o),
    .redirect_pc_o     (redirect_pc_o)
  );

  always #5 clk = ~clk;

  int nchecks = 0;
  int nerrors = 0;
  bit cmp_en  = 1'b0;

  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    nchecks++;
    if (a !== e) begin
      nerrors++;
      $display("FAIL %s: got %h expected %h at %0t", n, a, e, $time);
    end
  endtask

  // Model: each taken trap/mret becomes a list of per-cycle steps.
  typedef enum int {K_MEPC, K_MCAUSE, K_MST_T, K_JMP_T, K_MST_M, K_JMP_M} kind_e;
  typedef struct {
    kind_e       kind;
    logic [63:0] pc;
    logic [63:0] cause;
  } step_t;
  step_t q[$];

  function automatic logic [63:0] m_trap(input logic [63:0] m);
    return (m & ~64'h1888) | 64'h1800 | (m[3] ? 64'h80 : 64'h0);
  endfunction

  function automatic logic [63:0] m_mret(input logic [63:0] m);
    return (m & ~64'h1888) | 64'h1880 | (m[7] ? 64'h8 : 64'h0);
  endfunction

  function automatic logic [63:0] m_target(input logic [63:0] cause);
    logic [63:0] base;
    base = csr_mtvec_i & ~64'h3;
`ifdef CLINT_VECTORED_EN
    if (csr_mtvec_i[1:0] == 2'b01 && cause[63])
      return base + 4 * (cause & ~(64'h1 << 63));
`endif
    return base;
  endfunction

  function automatic bit m_irq();
    return inst_valid_i && global_int_en_i && mtime_int_en_i && mtime_int_pend_i;
  endfunction

  function automatic bit m_any();
    return m_irq() || (inst_valid_i && (inst_ecall_i || inst_mret_i));
  endfunction

  task automatic push_trap(input logic [63:0] pc, input logic [63:0] c);
    q.push_back('{K_MEPC, pc, c});
    q.push_back('{K_MCAUSE, pc, c});
    q.push_back('{K_MST_T, pc, c});
    q.push_back('{K_JMP_T, pc, c});
  endtask

  always @(posedge clk) begin
    if (rst) begin
      q.delete();
    end else if (q.size() > 0) begin
      void'(q.pop_front());
    end else if (m_irq()) begin
      push_trap(inst_pc_i, 64'h8000_0000_0000_0007);
    end else if (inst_valid_i && inst_ecall_i) begin
      push_trap(inst_pc_i, 64'd11);
    end else if (inst_valid_i && inst_mret_i) begin
      q.push_back('{K_MST_M, 64'h0, 64'h0});
      q.push_back('{K_JMP_M, 64'h0, 64'h0});
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      logic        e_wen, e_rv, e_hold;
      logic [11:0] e_addr;
      logic [63:0] e_data, e_rpc;
      e_wen = 0; e_rv = 0; e_addr = 0; e_data = 0; e_rpc = 0;
      e_hold = (q.size() > 0) || m_any();
      if (q.size() > 0) begin
        case (q[0].kind)
          K_MEPC:   begin e_wen = 1; e_addr = 12'h341; e_data = q[0].pc; end
          K_MCAUSE: begin e_wen = 1; e_addr = 12'h342; e_data = q[0].cause; end
          K_MST_T:  begin e_wen = 1; e_addr = 12'h300; e_data = m_trap(csr_mstatus_i); end
          K_MST_M:  begin e_wen = 1; e_addr = 12'h300; e_data = m_mret(csr_mstatus_i); end
          K_JMP_T:  begin e_rv = 1; e_rpc = m_target(q[0].cause); end
          K_JMP_M:  begin e_rv = 1; e_rpc = csr_mepc_i; end
          default: ;
        endcase
      end
      chk("mdl_wen", 64'(clint_csr_wen_o), 64'(e_wen));
      chk("mdl_addr", 64'(clint_csr_waddr_o), 64'(e_addr));
      chk("mdl_data", clint_csr_wdata_o, e_data);
      chk("mdl_hold", 64'(hold_o), 64'(e_hold));
      chk("mdl_rv", 64'(redirect_valid_o), 64'(e_rv));
      chk("mdl_rpc", redirect_pc_o, e_rpc);
    end
  end

  task automatic clr();
    inst_valid_i     = 0;
    inst_ecall_i     = 0;
    inst_mret_i      = 0;
    global_int_en_i  = 0;
    mtime_int_en_i   = 0;
    mtime_int_pend_i = 0;
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic after_edge();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [63:0] irq_tgt;
    rst = 1;
    inst_pc_i = 0;
    csr_mtvec_i = 0;
    csr_mepc_i = 0;
    csr_mstatus_i = 0;
    clr();
    after_edge();
    cmp_en = 1;
    @(negedge clk);
    chk("rst_wen", 64'(clint_csr_wen_o), 64'h0);
    chk("rst_hold", 64'(hold_o), 64'h0);
    chk("rst_rv", 64'(redirect_valid_o), 64'h0);
    after_edge();
    rst = 0;

    // ecall sequence
    csr_mtvec_i = 64'h8000_0100;
    csr_mstatus_i = 64'h1888;
    inst_pc_i = 64'h8000_0010;
    inst_valid_i = 1;
    inst_ecall_i = 1;
    @(negedge clk);
    chk("ec_hold_T", 64'(hold_o), 64'h1);
    chk("ec_wen_T", 64'(clint_csr_wen_o), 64'h0);
    after_edge();
    clr();
    @(negedge clk);
    chk("ec_mepc_addr", 64'(clint_csr_waddr_o), 64'h341);
    chk("ec_mepc", clint_csr_wdata_o, 64'h8000_0010);
    cyc();
    chk("ec_mcause_addr", 64'(clint_csr_waddr_o), 64'h342);
    chk("ec_mcause", clint_csr_wdata_o, 64'd11);
    cyc();
    chk("ec_mstat_addr", 64'(clint_csr_waddr_o), 64'h300);
    chk("ec_mstat", clint_csr_wdata_o, 64'h1880);
    cyc();
    chk("ec_rv_T4", 64'(redirect_valid_o), 64'h1);
    chk("ec_rpc", redirect_pc_o, 64'h8000_0100);
    cyc();
    chk("ec_rv_T5", 64'(redirect_valid_o), 64'h0);
    chk("ec_hold_T5", 64'(hold_o), 64'h0);

    // timer interrupt, pending kept high, MIE dropped by "software"
    after_edge();
    csr_mtvec_i = 64'h8000_0101;
    inst_pc_i = 64'h8000_0020;
    inst_valid_i = 1;
    global_int_en_i = 1;
    mtime_int_en_i = 1;
    mtime_int_pend_i = 1;
    after_edge();
    global_int_en_i = 0;
    @(negedge clk);
    chk("irq_mepc", clint_csr_wdata_o, 64'h8000_0020);
    cyc();
    chk("irq_mcause", clint_csr_wdata_o, 64'h8000_0000_0000_0007);
    cyc();
    cyc();
`ifdef CLINT_VECTORED_EN
    irq_tgt = 64'h8000_011C;
`else
    irq_tgt = 64'h8000_0100;
`endif
    chk("irq_rpc", redirect_pc_o, irq_tgt);
    cyc();
    chk("irq_masked_hold", 64'(hold_o), 64'h0);
    cyc();
    chk("irq_masked_wen", 64'(clint_csr_wen_o), 64'h0);
    after_edge();
    global_int_en_i = 1;
    @(negedge clk);
    chk("irq_reenable_hold", 64'(hold_o), 64'h1);
    after_edge();
    clr();
    repeat (5) cyc();

    // mret
    after_edge();
    csr_mstatus_i = 64'h0080;
    csr_mepc_i = 64'h8000_0024;
    inst_valid_i = 1;
    inst_mret_i = 1;
    @(negedge clk);
    chk("mret_hold_T", 64'(hold_o), 64'h1);
    after_edge();
    clr();
    @(negedge clk);
    chk("mret_mstat", clint_csr_wdata_o, 64'h1888);
    chk("mret_hold_T1", 64'(hold_o), 64'h1);
    cyc();
    chk("mret_rpc", redirect_pc_o, 64'h8000_0024);
    chk("mret_hold_T2", 64'(hold_o), 64'h1);
    cyc();
    chk("mret_hold_T3", 64'(hold_o), 64'h0);

    // irq and ecall together
    after_edge();
    csr_mtvec_i = 64'h8000_0100;
    inst_pc_i = 64'h8000_0030;
    inst_valid_i = 1;
    inst_ecall_i = 1;
    global_int_en_i = 1;
    mtime_int_en_i = 1;
    mtime_int_pend_i = 1;
    after_edge();
    clr();
    @(negedge clk);
    chk("both_mepc", clint_csr_wdata_o, 64'h8000_0030);
    cyc();
    chk("both_mcause", clint_csr_wdata_o, 64'h8000_0000_0000_0007);
    repeat (4) cyc();

    // reset while writing mcause
    after_edge();
    inst_pc_i = 64'h8000_0040;
    inst_valid_i = 1;
    inst_ecall_i = 1;
    after_edge();
    clr();
    after_edge();
    rst = 1;
    @(negedge clk);
    chk("rst_mid_addr", 64'(clint_csr_waddr_o), 64'h342);
    after_edge();
    rst = 0;
    @(negedge clk);
    chk("rst_mid_wen", 64'(clint_csr_wen_o), 64'h0);
    chk("rst_mid_hold", 64'(hold_o), 64'h0);
    cyc();
    chk("rst_mid_rv", 64'(redirect_valid_o), 64'h0);
    after_edge();
    inst_pc_i = 64'h8000_0050;
    inst_valid_i = 1;
    inst_ecall_i = 1;
    after_edge();
    clr();
    @(negedge clk);
    chk("rst_fresh_mepc", clint_csr_wdata_o, 64'h8000_0050);
    repeat (3) cyc();
    chk("rst_fresh_rpc", redirect_pc_o, 64'h8000_0100);

    // mixed stimulus checked by the model alone
    for (int i = 0; i < 400; i++) begin
      after_edge();
      rst = ($urandom_range(0, 49) == 0);
      inst_valid_i = $urandom_range(0, 1);
      inst_ecall_i = ($urandom_range(0, 3) == 0);
      inst_mret_i = ($urandom_range(0, 3) == 0);
      global_int_en_i = $urandom_range(0, 1);
      mtime_int_en_i = $urandom_range(0, 1);
      mtime_int_pend_i = $urandom_range(0, 1);
      inst_pc_i = {$urandom, $urandom};
      csr_mtvec_i = {$urandom, $urandom};
      csr_mepc_i = {$urandom, $urandom};
      csr_mstatus_i = {$urandom, $urandom};
    end
    after_edge();
    rst = 0;
    clr();
    repeat (6) cyc();

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
    $finish;
  end

endmodule

// File: doc/clint_ctrl.md
CLINT_CTRL -- requirements
Module: clint_ctrl

Interface
REQ-001 CLINT_VECTORED_EN, undefined, selects vectored interrupt target computation when defined.
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 inst_valid_i  input  1  the instruction at inst_pc_i is valid and at the trap decision point.
REQ-005 inst_pc_i  input  64  PC of the instruction at the decision point.
REQ-006 inst_ecall_i / inst_mret_i  input  1 each  decoded ECALL / MRET, qualified by inst_valid_i.
REQ-007 csr_mtvec_i / csr_mepc_i / csr_mstatus_i  input  64 each  current CSR values from the CSR file.
REQ-008 global_int_en_i / mtime_int_en_i / mtime_int_pend_i  input  1 each  mstatus.MIE, mie.MTIE, mip.MTIP.
REQ-009 clint_csr_wen_o  output  1  CSR write strobe to the CSR file clint port.
REQ-010 clint_csr_waddr_o  output  12  CSR write address; clint_csr_wdata_o  output  64  CSR write data.
REQ-011 hold_o  output  1  stalls the pipeline at and before the decision point.
REQ-012 redirect_valid_o  output  1, redirect_pc_o  output  64  one-cycle fetch redirect with target.

Function
REQ-013 Trap take (IDLE only): irq = inst_valid_i & global_int_en_i & mtime_int_en_i & mtime_int_pend_i; priority irq > ecall > mret.
REQ-014 On take, capture inst_pc_i and cause (irq: {1'b1,63'd7}; ecall: 64'd11) into internal registers in the same cycle.
REQ-015 States: IDLE, W_MEPC, W_MCAUSE, W_MSTAT, JUMP (trap path); M_MSTAT, JUMP (mret path).
REQ-016 Trap path: IDLE -> W_MEPC -> W_MCAUSE -> W_MSTAT -> JUMP -> IDLE, one cycle each, unconditional.
REQ-017 Mret path: IDLE -> M_MSTAT -> JUMP -> IDLE.
REQ-018 W_MEPC: wen=1, addr 0x341, data = captured PC (for irq the interrupted instruction re-executes).
REQ-019 W_MCAUSE: wen=1, addr 0x342, data = captured cause.
REQ-020 W_MSTAT: wen=1, addr 0x300, data = csr_mstatus_i with MPIE[7]=MIE[3], MIE[3]=0, MPP[12:11]=2'b11, other bits unchanged.
REQ-021 M_MSTAT: wen=1, addr 0x300, data = csr_mstatus_i with MIE[3]=MPIE[7], MPIE[7]=1, MPP[12:11]=2'b11.
REQ-022 JUMP: redirect_valid_o=1 for exactly one cycle; trap target = {csr_mtvec_i[63:2],2'b00}; mret target = csr_mepc_i.
REQ-023 clint_csr_wen_o=0 in IDLE and JUMP; addr/data = 0 when wen=0; redirect_pc_o = 0 when redirect_valid_o=0.
REQ-024 hold_o = (state != IDLE) | take-condition (combinational in take cycle), so no upstream CPU CSR write overlaps the sequence.
REQ-025 New takes ignored outside IDLE; pending/ecall/mret inputs sampled again only in IDLE after JUMP.
REQ-026 Latency: take cycle T -> redirect_valid_o at T+4 (trap) or T+2 (mret).
REQ-027 MIE cleared by W_MSTAT masks re-entry; a still-pending timer irq is taken only after software re-enables MIE.

Reset
REQ-028 rst=1 forces state IDLE, captured PC/cause to 0, all outputs 0, within the same edge, including mid-sequence; partially written CSRs are not restored.

Configuration
REQ-029 CLINT_VECTORED_EN defined: when csr_mtvec_i[1:0]==2'b01 and cause is an interrupt, trap target = {mtvec[63:2],2'b00} + 4*cause[62:0]; exceptions use base.
REQ-030 CLINT_VECTORED_EN undefined: mtvec[1:0] ignored, all traps jump to base.

Verification
REQ-031 ecall at pc 0x8000_0010, mtvec 0x8000_0100, mstatus 0x1888 -> writes mepc=0x8000_0010, mcause=11, mstatus=0x1880; redirect 0x8000_0100 at T+4.
REQ-032 MIE=1, MTIE=1, MTIP=1, pc 0x8000_0020 -> mcause=0x8000_0000_0000_0007, mepc=0x8000_0020; vectored build with mtvec 0x8000_0101 redirects 0x8000_011C, non-vectored 0x8000_0100.
REQ-033 mret, mstatus 0x0080, mepc 0x8000_0024 -> mstatus write 0x1888, redirect 0x8000_0024 at T+2; hold_o high T..T+2.
REQ-034 irq and ecall in same cycle -> interrupt taken, mcause bit63=1, mepc = ecall PC; ecall not separately taken.
REQ-035 rst asserted in W_MCAUSE -> next cycle IDLE, wen=0, hold_o=0, no redirect; fresh ecall afterwards completes full sequence.
